// File: rtl/deskew_axil_slave.sv
// AXI4-Lite slave front end for the deskew register block.
// Converts AXI4-Lite reads/writes into single-cycle read_reg/write_reg strobes.
// Write and read paths are independent; each allows at most one outstanding transaction.
module deskew_axil_slave #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_ADDR   = 32'h10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // AW channel
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    // W channel
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    // B channel
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    // AR channel
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    // R channel
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    // Register block side
    output logic                  write_reg,
    output logic [ADDR_WIDTH-1:0] reg_waddr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  read_reg,
    output logic [ADDR_WIDTH-1:0] reg_raddr,
    input  logic [DATA_WIDTH-1:0] reg_rdata
);

    localparam int unsigned STRB_WIDTH  = 4;
    localparam int unsigned RESP_WIDTH  = 2;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = 2'b10;
    localparam logic [STRB_WIDTH-1:0] STRB_FULL   = 4'hF;

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_RESP} rstate_e;

    // Word-aligned and inside the mapped window.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00) && (addr <= ADDR_WIDTH'(MAX_ADDR));
    endfunction

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wstate_e                 wstate_q, wstate_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;
    logic                    write_reg_q, write_reg_d;
    logic [ADDR_WIDTH-1:0]   reg_waddr_q, reg_waddr_d;
    logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;
    logic                    aw_hs, w_hs, wr_ok;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rstate_e                 rstate_q, rstate_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;
    logic                    read_reg_q, read_reg_d;
    logic [ADDR_WIDTH-1:0]   reg_raddr_q, reg_raddr_d;
    logic                    ar_hs, rd_ok;

    // Write path next-state: capture AW/W independently, strobe once both are held.
    always_comb begin
        wstate_d    = wstate_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        write_reg_d = 1'b0;
        reg_waddr_d = reg_waddr_q;
        reg_wdata_d = reg_wdata_q;
        wr_ok       = 1'b0;
        aw_hs       = s_awvalid & awready_q;
        w_hs        = s_wvalid & wready_q;

        case (wstate_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = s_awaddr;
                    awready_d = 1'b0;
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = s_wdata;
                    wstrb_d  = s_wstrb;
                    wready_d = 1'b0;
                end
                // Strobe is launched on entry so it is visible during W_REQ.
                if (aw_held_d && w_held_d) begin
                    wstate_d  = W_REQ;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    wr_ok     = addr_ok(awaddr_d) && (wstrb_d == STRB_FULL);
                    if (wr_ok) begin
                        write_reg_d = 1'b1;
                        reg_waddr_d = awaddr_d;
                        reg_wdata_d = wdata_d;
                        bresp_d     = RESP_OKAY;
                    end else begin
                        bresp_d     = RESP_SLVERR;
                    end
                end
            end
            W_REQ: begin
                wstate_d = W_RESP;
                bvalid_d = 1'b1;
            end
            W_RESP: begin
                if (s_bready) begin
                    wstate_d  = W_IDLE;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    // Write path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate_q    <= W_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awready_q   <= 1'b1;
            wready_q    <= 1'b1;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            write_reg_q <= 1'b0;
            reg_waddr_q <= '0;
            reg_wdata_q <= '0;
        end else begin
            wstate_q    <= wstate_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            write_reg_q <= write_reg_d;
            reg_waddr_q <= reg_waddr_d;
            reg_wdata_q <= reg_wdata_d;
        end
    end

    // Read path next-state: capture AR, strobe for one cycle, then hold the response.
    always_comb begin
        rstate_d    = rstate_q;
        arready_d   = arready_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        read_reg_d  = 1'b0;
        reg_raddr_d = reg_raddr_q;
        rd_ok       = 1'b0;
        ar_hs       = s_arvalid & arready_q;

        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d    = R_REQ;
                    arready_d   = 1'b0;
                    reg_raddr_d = s_araddr;
                    rd_ok       = addr_ok(s_araddr);
                    read_reg_d  = rd_ok;
                    rresp_d     = rd_ok ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_REQ: begin
                rstate_d = R_RESP;
                rvalid_d = 1'b1;
            end
            R_RESP: begin
                if (s_rready) begin
                    rstate_d  = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    // Read path registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate_q    <= R_IDLE;
            arready_q   <= 1'b1;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            read_reg_q  <= 1'b0;
            reg_raddr_q <= '0;
        end else begin
            rstate_q    <= rstate_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rresp_q     <= rresp_d;
            read_reg_q  <= read_reg_d;
            reg_raddr_q <= reg_raddr_d;
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign write_reg = write_reg_q;
    assign reg_waddr = reg_waddr_q;
    assign reg_wdata = reg_wdata_q;

    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign read_reg  = read_reg_q;
    assign reg_raddr = reg_raddr_q;

    // reg_rdata arrives the cycle after read_reg and is already registered and held
    // by the register block, so it is forwarded directly to meet the T+2 R timing.
    assign s_rdata = (rresp_q == RESP_OKAY) ? reg_rdata : '0;

endmodule

// File: tb/tb_deskew_axil_slave.sv
// Self-checking bench for deskew_axil_slave: directed cases plus randomized traffic
// against a transaction-level register map model.
module tb_deskew_axil_slave;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;
    logic [AW-1:0] s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic          write_reg;
    logic [AW-1:0] reg_waddr;
    logic [DW-1:0] reg_wdata;
    logic          read_reg;
    logic [AW-1:0] reg_raddr;
    logic [DW-1:0] reg_rdata;

    deskew_axil_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_ADDR(32'h10)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .write_reg(write_reg), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .read_reg(read_reg), .reg_raddr(reg_raddr), .reg_rdata(reg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Simple register block: stores whatever the strobes deliver.
    logic [DW-1:0] regs_blk [256] = '{default: '0};
    always @(posedge clk) begin
        if (write_reg) regs_blk[reg_waddr] <= reg_wdata;
        if (read_reg)  reg_rdata <= regs_blk[reg_raddr];
    end

    // Reference register map: what the CPU should see.
    logic [DW-1:0] model [256] = '{default: '0};

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ev_t;
    ev_t wq[$];
    ev_t rq[$];

    // Record every strobe cycle seen on the register-block side.
    always @(negedge clk) begin
        if (write_reg) wq.push_back('{cyc, reg_waddr, reg_wdata});
        if (read_reg)  rq.push_back('{cyc, reg_raddr, '0});
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit mapped(input logic [AW-1:0] a);
        return (int'(a) % 4 == 0) && (int'(a) <= 16);
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] st,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit good;
        int hs_c = 0;
        int k;
        good = mapped(a) && (st == 4'hF);
        wq.delete();
        for (k = 0; k < 40 && !(aw_done && w_done); k++) begin
            @(negedge clk);
            if (w_done && !aw_done) chk("wready_low_after_w", 32'(s_wready), 0);
            if (aw_done && !w_done) chk("awready_low_after_aw", 32'(s_awready), 0);
            s_awaddr  = a;
            s_wdata   = d;
            s_wstrb   = st;
            s_awvalid = !aw_done && (k >= aw_dly);
            s_wvalid  = !w_done && (k >= w_dly);
            if (s_awvalid && s_awready) aw_done = 1;
            if (s_wvalid && s_wready)   w_done  = 1;
            hs_c = cyc;
        end
        if (!(aw_done && w_done)) begin
            chk("aw_w_handshake_timeout", 0, 1);
            s_awvalid = 0; s_wvalid = 0;
            return;
        end
        @(negedge clk);
        s_awvalid = 0;
        s_wvalid  = 0;
        s_bready  = (b_dly == 0);
        k = 0;
        while (!s_bvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!s_bvalid) begin
            chk("bvalid_timeout", 0, 1);
            s_bready = 0;
            return;
        end
        chk("bvalid_latency", 32'(cyc - hs_c), 2);
        chk("bresp", 32'(s_bresp), good ? 0 : 2);
        for (int j = 0; j < b_dly; j++) begin
            chk("bvalid_hold", 32'(s_bvalid), 1);
            chk("bresp_hold", 32'(s_bresp), good ? 0 : 2);
            chk("awready_busy", 32'({s_awready, s_wready}), 0);
            @(negedge clk);
        end
        s_bready = 1;
        @(negedge clk);
        s_bready = 0;
        chk("bvalid_clear", 32'(s_bvalid), 0);
        chk("aw_w_ready_back", 32'({s_awready, s_wready}), 3);
        chk("write_strobes", 32'(wq.size()), good ? 1 : 0);
        if (good && wq.size() > 0) begin
            chk("write_strobe_cycle", 32'(wq[0].c - hs_c), 1);
            chk("reg_waddr", 32'(wq[0].a), 32'(a));
            chk("reg_wdata", wq[0].d, d);
        end
        if (good) model[a] = d;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly);
        bit ar_done = 0;
        bit good;
        logic [DW-1:0] exp;
        int hs_c = 0;
        int k;
        good = mapped(a);
        exp  = good ? model[a] : '0;
        rq.delete();
        for (k = 0; k < 40 && !ar_done; k++) begin
            @(negedge clk);
            s_araddr  = a;
            s_arvalid = (k >= ar_dly);
            if (s_arvalid && s_arready) begin
                ar_done = 1;
                hs_c = cyc;
            end
        end
        if (!ar_done) begin
            chk("ar_handshake_timeout", 0, 1);
            s_arvalid = 0;
            return;
        end
        @(negedge clk);
        s_arvalid = 0;
        s_rready  = (r_dly == 0);
        k = 0;
        while (!s_rvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!s_rvalid) begin
            chk("rvalid_timeout", 0, 1);
            s_rready = 0;
            return;
        end
        chk("rvalid_latency", 32'(cyc - hs_c), 2);
        chk("rresp", 32'(s_rresp), good ? 0 : 2);
        chk("rdata", s_rdata, exp);
        for (int j = 0; j < r_dly; j++) begin
            chk("rvalid_hold", 32'(s_rvalid), 1);
            chk("rdata_hold", s_rdata, exp);
            chk("rresp_hold", 32'(s_rresp), good ? 0 : 2);
            chk("arready_busy", 32'(s_arready), 0);
            s_araddr  = 8'h08;
            s_arvalid = 1;
            @(negedge clk);
        end
        s_arvalid = 0;
        s_rready  = 1;
        @(negedge clk);
        s_rready = 0;
        chk("rvalid_clear", 32'(s_rvalid), 0);
        chk("arready_back", 32'(s_arready), 1);
        chk("read_strobes", 32'(rq.size()), good ? 1 : 0);
        if (good && rq.size() > 0) begin
            chk("read_strobe_cycle", 32'(rq[0].c - hs_c), 1);
            chk("reg_raddr", 32'(rq[0].a), 32'(a));
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 5) == 0) return AW'($urandom());
        return AW'(4 * $urandom_range(0, 4));
    endfunction

    initial begin
        bit seen;
        rst_n = 0;
        s_awaddr = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0; s_bready = 0;
        s_araddr = '0; s_arvalid = 0; s_rready = 0;
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({write_reg, read_reg}), 0);
        chk("rst_valids", 32'({s_bvalid, s_rvalid}), 0);
        chk("rst_resps", 32'({s_bresp, s_rresp}), 0);
        chk("rst_reg_waddr", 32'(reg_waddr), 0);
        chk("rst_reg_wdata", reg_wdata, 0);
        chk("rst_reg_raddr", 32'(reg_raddr), 0);
        rst_n = 1;
        @(negedge clk);

        // Directed cases
        do_write(8'h04, 32'h00A0_0010, 4'hF, 0, 0, 0);
        do_read(8'h04, 0, 0);
        do_write(8'h08, 32'h0000_0100, 4'hF, 3, 0, 0);
        do_read(8'h08, 1, 0);
        do_write(8'h14, 32'h1111_2222, 4'hF, 0, 0, 0);
        do_write(8'h06, 32'h3333_4444, 4'hF, 0, 1, 0);
        do_read(8'h20, 0, 0);
        do_write(8'h04, 32'hFFFF_FFFF, 4'h3, 0, 0, 0);
        do_read(8'h04, 0, 0);
        do_write(8'h0C, 32'hCAFE_0C0C, 4'hF, 0, 0, 5);
        do_write(8'h10, 32'h1234_0010, 4'hF, 2, 0, 0);
        do_read(8'h0C, 0, 5);
        do_read(8'h10, 0, 0);

        // Reset while the write is in its strobe cycle
        @(negedge clk);
        chk("pre_rst_awready", 32'({s_awready, s_wready}), 3);
        s_awaddr = 8'h08; s_wdata = 32'hDEAD_BEEF; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1; s_bready = 1;
        @(negedge clk);
        s_awvalid = 0; s_wvalid = 0;
        chk("wreq_strobe", 32'(write_reg), 1);
        #2 rst_n = 0;
        #1 chk("rst_in_wreq_strobe", 32'(write_reg), 0);
        chk("rst_in_wreq_bvalid", 32'(s_bvalid), 0);
        wq.delete();
        @(negedge clk);
        rst_n = 1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_bvalid || write_reg) seen = 1;
        end
        chk("no_residual_write", 32'(seen), 0);
        s_bready = 0;

        // Reset while the read response is pending
        @(negedge clk);
        s_araddr = 8'h04; s_arvalid = 1; s_rready = 0;
        @(negedge clk);
        s_arvalid = 0;
        @(negedge clk);
        chk("rresp_pending", 32'(s_rvalid), 1);
        #2 rst_n = 0;
        #1 chk("rst_in_rresp_rvalid", 32'(s_rvalid), 0);
        chk("rst_in_rresp_read_reg", 32'(read_reg), 0);
        chk("rst_in_rresp_rresp", 32'(s_rresp), 0);
        @(negedge clk);
        rst_n = 1;
        s_rready = 1;
        rq.delete();
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_rvalid || read_reg) seen = 1;
        end
        chk("no_residual_read", 32'(seen), 0);
        s_rready = 0;
        do_write(8'h08, 32'h5A5A_1234, 4'hF, 0, 0, 0);
        do_read(8'h08, 0, 0);

        // Randomized traffic, including concurrent read/write
        for (int i = 0; i < 60; i++) begin
            logic [AW-1:0] wa, ra;
            logic [DW-1:0] wd;
            logic [3:0]    st;
            int            mode;
            wa   = rand_addr();
            ra   = rand_addr();
            wd   = $urandom();
            st   = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                do_write(wa, wd, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (mode == 1) begin
                do_read(ra, $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                if (ra == wa) ra = ra ^ 8'h04;
                fork
                    do_write(wa, wd, st, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
                    do_read(ra, $urandom_range(0, 2), $urandom_range(0, 2));
                join
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/deskew_axil_slave.md
Name: deskew_axil_slave

Overview:
- AXI4-Lite slave front end of the deskew IP. It terminates the CPU-side AXI4-Lite bus and converts each transaction into single-cycle read_reg/write_reg strobes toward the deskew register block.
- Sits directly upstream of the register block.
- Returns that block's registered read data on the R channel and completes writes on the B channel.
- Write path and read path are independent FSMs.

Parameters:
- ADDR_WIDTH, 8, width of AXI address and of reg_waddr/reg_raddr.
- DATA_WIDTH, 32, width of AXI data and of register data; fixed at 32.
- MAX_ADDR, 8'h10, highest mapped word address; anything above is unmapped.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- s_awaddr  input  ADDR_WIDTH  write address
- s_awvalid  input  1  write address valid
- s_awready  output  1  write address ready
- s_wdata  input  DATA_WIDTH  write data
- s_wstrb  input  4  write byte strobes
- s_wvalid  input  1  write data valid
- s_wready  output  1  write data ready
- s_bresp  output  2  write response (00 OKAY, 10 SLVERR)
- s_bvalid  output  1  write response valid
- s_bready  input  1  write response ready
- s_araddr  input  ADDR_WIDTH  read address
- s_arvalid  input  1  read address valid
- s_arready  output  1  read address ready
- s_rdata  output  DATA_WIDTH  read data
- s_rresp  output  2  read response
- s_rvalid  output  1  read data valid
- s_rready  input  1  read data ready
- write_reg  output  1  one-cycle write strobe to register block
- reg_waddr  output  ADDR_WIDTH  write address to register block
- reg_wdata  output  DATA_WIDTH  write data to register block
- read_reg  output  1  one-cycle read strobe to register block
- reg_raddr  output  ADDR_WIDTH  read address to register block
- reg_rdata  input  DATA_WIDTH  registered read data from register block; valid the cycle after read_reg, held until the next read_reg

Behaviour:
- Reset (asynchronous, rst_n low):
  - Both FSMs go to IDLE.
  - write_reg, read_reg, s_bvalid, s_rvalid = 0; s_bresp, s_rresp = 00; reg_waddr, reg_wdata, reg_raddr = 0.
  - Captured AW/W/AR payloads are discarded. Reset mid-transaction drops the transaction; no strobe or response is issued afterwards.
- Address check: a transaction is an error if addr[1:0] != 0 or addr > MAX_ADDR.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
  - W_IDLE:
    - s_awready = ~aw_held; s_wready = ~w_held.
    - AW and W are captured independently, in either order or the same cycle.
    - When both are held, or become held this cycle, go to W_REQ.
  - W_REQ (one cycle):
    - If the address is valid and s_wstrb == 4'hF: write_reg = 1, reg_waddr/reg_wdata driven from the captured values, bresp = OKAY.
    - Otherwise: no strobe, bresp = SLVERR. Partial strobes are never written.
    - Go to W_RESP.
  - W_RESP: s_bvalid = 1, s_bresp stable. On s_bready, clear aw_held/w_held and go to W_IDLE.
  - s_awready and s_wready are 0 outside W_IDLE.
  - Minimum write cycle is 3 clocks: handshake, strobe, response with bready = 1.
- Read FSM states: R_IDLE, R_REQ, R_RESP.
  - R_IDLE: s_arready = 1. On s_arvalid, capture the address into reg_raddr and go to R_REQ.
  - R_REQ (one cycle):
    - read_reg = 1 if the address is valid, rresp = OKAY; else no strobe, rresp = SLVERR.
    - Go to R_RESP.
  - R_RESP:
    - s_rvalid = 1; s_rdata = reg_rdata when OKAY, 0 when SLVERR. The value is stable because reg_rdata holds.
    - On s_rready, go to R_IDLE.
  - s_arready is 0 outside R_IDLE. AR handshake at cycle T gives s_rvalid at T+2.
- Reads and writes are fully concurrent. write_reg and read_reg may assert in the same cycle; the register block handles each independently.
- Read-only and ack addresses (0x0C, 0x10) are mapped: writes strobe normally and return OKAY.
- Backpressure:
  - s_bvalid and s_rvalid stay asserted with all payload stable until accepted.
  - No new transaction is accepted on a channel while its response is pending. There is at most one outstanding transaction per direction.

Test Plan:
- Write 0x04 / 0x00A00010 with AW and W in the same cycle, bready = 1 -> write_reg pulse 1 cycle with reg_waddr = 0x04, reg_wdata = 0x00A00010; bvalid next cycle, bresp = 00; then read 0x04 returns rdata = 0x00A00010, rresp = 00, rvalid 2 cycles after AR.
- W 3 cycles before AW (addr 0x08, data 0x100) -> wready drops after W capture; single write_reg 1 cycle after AW handshake; bresp = 00.
- Write to 0x14, then to 0x06 -> no write_reg pulse for either; bresp = 10. Read 0x20 -> no read_reg, rdata = 0, rresp = 10.
- Write 0x04 with wstrb = 4'h3 -> no write_reg; bresp = 10.
- bready and rready held low 5 cycles -> bvalid/rvalid, bresp/rresp, rdata stable; awready/wready/arready stay 0; a new AR offered meanwhile is accepted only after rready.
- rst_n asserted in W_REQ and in R_RESP -> bvalid/rvalid/write_reg/read_reg = 0 immediately; after release, no residual response; the next write completes normally.
